nibble_packer: RTL

- Streaming stage that collects 4-bit nibbles and concatenates pairs into 8-bit bytes.
- Packed bytes are buffered in a small FIFO for a downstream byte consumer.
- Sits upstream of the byte-slicing/field-extract logic; the downstream stage splits bytes with part-selects ([7:4], [3:2], ...).
- Valid/ready handshake on both sides; explicit flush pads a dangling nibble.

---
 rtl/nibble_pkg.sv | 21 ++
 rtl/nibble_packer_if.sv | 34 +++
 rtl/nibble_packer_byte_fifo.sv | 50 +++++
 rtl/nibble_packer.sv | 118 +++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// Shared widths, FSM state type and byte-assembly helpers for nibble_packer.
package nibble_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} pack_state_t;
  typedef logic [BYTE_W-1:0] byte_t;

  // Lone nibble padded with zeros in the half it would have occupied as first nibble.
  function automatic byte_t pad_nib(input logic [NIB_W-1:0] nib, input bit msb_first);
    return msb_first ? {nib, 4'h0} : {4'h0, nib};
  endfunction

  function automatic byte_t pair_nib(input logic [NIB_W-1:0] first,
                                     input logic [NIB_W-1:0] second,
                                     input bit msb_first);
    return msb_first ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/nibble_packer_if.sv
// Nibble-in / byte-out handshake bundle for nibble_packer.
// Optional NIBBLE_PACKER_PARITY_EN adds out_par and half_pend.
interface nibble_packer_if
  import nibble_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [NIB_W-1:0]  in_nib;
  logic              in_flush;
  logic              out_valid;
  logic              out_ready;
  byte_t             out_byte;
  logic [LVL_W-1:0]  level;
`ifdef NIBBLE_PACKER_PARITY_EN
  logic              out_par;
  logic              half_pend;

  modport master (output in_valid, in_nib, in_flush, out_ready,
                  input  in_ready, out_valid, out_byte, level, out_par, half_pend);
  modport slave  (input  in_valid, in_nib, in_flush, out_ready,
                  output in_ready, out_valid, out_byte, level, out_par, half_pend);
`else
  modport master (output in_valid, in_nib, in_flush, out_ready,
                  input  in_ready, out_valid, out_byte, level);
  modport slave  (input  in_valid, in_nib, in_flush, out_ready,
                  output in_ready, out_valid, out_byte, level);
`endif

endinterface

// File: rtl/nibble_packer_byte_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide even when full.
module byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [WIDTH-1:0]           dout_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign level_d = level_q + LW'(do_push) - LW'(do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/nibble_packer.sv
// Packs pairs of nibbles into bytes and queues them for a byte consumer.
// Optional NIBBLE_PACKER_PARITY_EN stores even parity per byte and exposes half_pend.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned DEPTH     = 4
) (
  input  logic            clk,
  input  logic            rst,
  nibble_packer_if.slave  bus
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
`ifdef NIBBLE_PACKER_PARITY_EN
  localparam int unsigned FW = BYTE_W + 1;
`else
  localparam int unsigned FW = BYTE_W;
`endif

  pack_state_t      state_q, state_d;
  logic [NIB_W-1:0] hold_q, hold_d;
  logic             pend_q, pend_d;
  logic             push;
  byte_t            push_byte;
  logic             fifo_full, fifo_empty, pop, can_push, in_ready_c, accept;
  logic [FW-1:0]    fifo_din, fifo_dout;
  logic [LW-1:0]    fifo_level;

  // A pop in the same cycle frees the slot, so a full FIFO can still take a byte.
  assign pop        = bus.out_ready && !fifo_empty;
  assign can_push   = !fifo_full || pop;
  assign in_ready_c = !rst && ((state_q == EMPTY) || (can_push && !pend_q));
  assign accept     = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    push      = 1'b0;
    push_byte = '0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          if (bus.in_flush && can_push) begin
            push      = 1'b1;
            push_byte = pad_nib(bus.in_nib, MSB_FIRST);
          end else begin
            // A flush that cannot push yet is remembered and drained from HALF.
            hold_d  = bus.in_nib;
            state_d = HALF;
            pend_d  = bus.in_flush;
          end
        end
      end
      HALF: begin
        if (accept) begin
          push      = 1'b1;
          push_byte = pair_nib(hold_q, bus.in_nib, MSB_FIRST);
          hold_d    = '0;
          state_d   = EMPTY;
          pend_d    = 1'b0;
        end else if (pend_q || bus.in_flush) begin
          if (can_push) begin
            push      = 1'b1;
            push_byte = pad_nib(hold_q, MSB_FIRST);
            hold_d    = '0;
            state_d   = EMPTY;
            pend_d    = 1'b0;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

`ifdef NIBBLE_PACKER_PARITY_EN
  assign fifo_din = {^push_byte, push_byte};
`else
  assign fifo_din = push_byte;
`endif

  byte_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level),
    .dout_o  (fifo_dout)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_byte  = fifo_dout[BYTE_W-1:0];
  assign bus.level     = fifo_level;
`ifdef NIBBLE_PACKER_PARITY_EN
  assign bus.out_par   = fifo_dout[BYTE_W];
  assign bus.half_pend = (state_q == HALF);
`endif

endmodule
